// File: rtl/ttl_gate_bank.sv
// ttl_gate_bank: CHANNELS independent INPUTS-input logic gates sharing one run-time
// function select. Each gate output passes through a DELAY-stage pipe that emulates
// TTL propagation delay, then through an optional glitch filter, before reaching y.
// y_edge flags, one cycle late, every cycle in which y toggled.
module ttl_gate_bank #(
  parameter int                  CHANNELS = 4,
  parameter int                  INPUTS   = 2,
  parameter int                  DELAY    = 1,
  parameter int                  FILTER   = 0,
  parameter logic [CHANNELS-1:0] RESET_Y  = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [2:0]                   mode,
  input  logic [CHANNELS*INPUTS-1:0]   a,
  output logic [CHANNELS-1:0]          y,
  output logic [CHANNELS-1:0]          y_edge
);

  typedef enum logic [2:0] {
    MODE_NOR  = 3'd0,
    MODE_OR   = 3'd1,
    MODE_NAND = 3'd2,
    MODE_AND  = 3'd3,
    MODE_XOR  = 3'd4,
    MODE_XNOR = 3'd5,
    MODE_BUF  = 3'd6,
    MODE_INV  = 3'd7
  } gate_mode_e;

  // Out-of-range configurations stop elaboration instead of building a broken part.
  generate
    if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
      $fatal(1, "ttl_gate_bank: CHANNELS must be 1..32");
    end
    if (INPUTS < 2 || INPUTS > 8) begin : g_bad_inputs
      $fatal(1, "ttl_gate_bank: INPUTS must be 2..8");
    end
    if (DELAY < 1 || DELAY > 8) begin : g_bad_delay
      $fatal(1, "ttl_gate_bank: DELAY must be 1..8");
    end
    if (FILTER < 0 || FILTER > 15) begin : g_bad_filter
      $fatal(1, "ttl_gate_bank: FILTER must be 0..15");
    end
  endgenerate

  // One gate evaluated on its own input slice; XOR/XNOR are odd/even parity,
  // BUF/INV look at input 0 only.
  function automatic logic gate_fn(input logic [2:0] sel, input logic [INPUTS-1:0] v);
    logic r;
    case (gate_mode_e'(sel))
      MODE_NOR:  r = ~(|v);
      MODE_OR:   r = |v;
      MODE_NAND: r = ~(&v);
      MODE_AND:  r = &v;
      MODE_XOR:  r = ^v;
      MODE_XNOR: r = ~(^v);
      MODE_BUF:  r = v[0];
      default:   r = ~v[0];
    endcase
    return r;
  endfunction

  logic [CHANNELS-1:0] g;
  logic [CHANNELS-1:0] pipe [DELAY];
  logic [CHANNELS-1:0] d;
  logic [CHANNELS-1:0] y_prev;

  // Combinational gate function for every channel.
  always_comb begin
    // NOTE: default assignment first so no path through this block leaves g unassigned
    // and infers a latch.
    g = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      g[c] = gate_fn(mode, a[c*INPUTS +: INPUTS]);
    end
  end

  // Propagation-delay pipe: stage 0 captures g, later stages shift one per cycle.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every stage samples its neighbour's old value;
    // blocking here would collapse the pipe into a single stage.
    if (rst) begin
      // NOTE: the pipe is reset stage by stage on purpose: stale gate levels must not
      // drain out after reset, so this storage cannot be left uninitialised.
      for (int s = 0; s < DELAY; s++) begin
        pipe[s] <= RESET_Y;
      end
    end else begin
      pipe[0] <= g;
      for (int s = 1; s < DELAY; s++) begin
        pipe[s] <= pipe[s-1];
      end
    end
  end

  assign d = pipe[DELAY-1];

  generate
    if (FILTER == 0) begin : g_no_filter
      // Unfiltered output: y simply registers the delayed gate level.
      always_ff @(posedge clk) begin
        if (rst) y <= RESET_Y;
        else     y <= d;
      end
    end else begin : g_filter
      localparam logic [3:0] LAST = 4'(FILTER - 1);
      logic [3:0] cnt [CHANNELS];

      // Glitch filter: y takes a new level only after d has disagreed with y for
      // FILTER consecutive cycles; any return to agreement restarts the count.
      always_ff @(posedge clk) begin
        if (rst) begin
          y <= RESET_Y;
          for (int c = 0; c < CHANNELS; c++) begin
            cnt[c] <= '0;
          end
        end else begin
          for (int c = 0; c < CHANNELS; c++) begin
            if (d[c] == y[c]) begin
              cnt[c] <= '0;
            end else if (cnt[c] == LAST) begin
              y[c]   <= d[c];
              cnt[c] <= '0;
            end else begin
              cnt[c] <= cnt[c] + 4'd1;
            end
          end
        end
      end
    end
  endgenerate

  // Edge flag: registered compare of y against its previous value.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_prev <= RESET_Y;
      y_edge <= '0;
    end else begin
      y_prev <= y;
      y_edge <= y ^ y_prev;
    end
  end

endmodule

// File: tb/tb_ttl_gate_bank.sv
// Bench for ttl_gate_bank. Three instances cover the plain, wide-input and filtered
// configurations; a behavioural model tracks all three every clock.
module tb_ttl_gate_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] m1, m2, m3;
  logic [7:0] a1;
  logic [5:0] a2;
  logic [7:0] a3;
  logic [3:0] y1, e1;
  logic [1:0] y2, e2;
  logic [3:0] y3, e3;

  int total = 0;
  int bad   = 0;

  // u1: 4 ch x 2 in, DELAY 1, no filter
  ttl_gate_bank #(.CHANNELS(4), .INPUTS(2), .DELAY(1), .FILTER(0), .RESET_Y(4'b0000)) u1 (
    .clk(clk), .rst(rst), .mode(m1), .a(a1), .y(y1), .y_edge(e1));
  // u2: 2 ch x 3 in, DELAY 2, no filter, non-zero reset value
  ttl_gate_bank #(.CHANNELS(2), .INPUTS(3), .DELAY(2), .FILTER(0), .RESET_Y(2'b10)) u2 (
    .clk(clk), .rst(rst), .mode(m2), .a(a2), .y(y2), .y_edge(e2));
  // u3: 4 ch x 2 in, DELAY 4, FILTER 3
  ttl_gate_bank #(.CHANNELS(4), .INPUTS(2), .DELAY(4), .FILTER(3), .RESET_Y(4'b0000)) u3 (
    .clk(clk), .rst(rst), .mode(m3), .a(a3), .y(y3), .y_edge(e3));

  // ---------------- reference model ----------------
  function automatic int cfg_ch(int k); return (k == 1) ? 2 : 4; endfunction
  function automatic int cfg_in(int k); return (k == 1) ? 3 : 2; endfunction
  function automatic int cfg_dl(int k); return (k == 0) ? 1 : ((k == 1) ? 2 : 4); endfunction
  function automatic int cfg_fl(int k); return (k == 2) ? 3 : 0; endfunction
  function automatic logic [3:0] cfg_ry(int k); return (k == 1) ? 4'b0010 : 4'b0000; endfunction

  // Gate truth defined by counting ones among the channel's n inputs.
  function automatic logic g_ref(input logic [2:0] md, input int n, input logic [7:0] v);
    logic [7:0] vv;
    int ones;
    vv   = v & 8'((1 << n) - 1);
    ones = $countones(vv);
    case (md)
      3'd0:    return ones == 0;
      3'd1:    return ones != 0;
      3'd2:    return ones != n;
      3'd3:    return ones == n;
      3'd4:    return (ones % 2) == 1;
      3'd5:    return (ones % 2) == 0;
      3'd6:    return vv[0];
      default: return !vv[0];
    endcase
  endfunction

  logic [3:0] m_pipe [3][8];   // gate history, index 0 newest
  logic [3:0] m_y  [3];
  logic [3:0] m_yp [3];
  logic [3:0] m_ye [3];
  int         m_run [3][4];    // consecutive cycles delayed level has disagreed with y

  task automatic model_step(input int k, input logic r, input logic [2:0] md, input logic [7:0] av);
    int ch, n, dl, fl;
    logic [3:0] d, ny, ng;
    ch = cfg_ch(k); n = cfg_in(k); dl = cfg_dl(k); fl = cfg_fl(k);
    if (r) begin
      for (int s = 0; s < 8; s++) m_pipe[k][s] = cfg_ry(k);
      m_y[k] = cfg_ry(k); m_yp[k] = cfg_ry(k); m_ye[k] = 4'h0;
      for (int c = 0; c < 4; c++) m_run[k][c] = 0;
    end else begin
      d  = m_pipe[k][dl-1];
      ny = m_y[k];
      for (int c = 0; c < ch; c++) begin
        if (fl == 0) ny[c] = d[c];
        else if (d[c] == m_y[k][c]) m_run[k][c] = 0;
        else begin
          m_run[k][c]++;
          if (m_run[k][c] == fl) begin
            ny[c] = d[c];
            m_run[k][c] = 0;
          end
        end
      end
      ng = 4'h0;
      for (int c = 0; c < ch; c++) ng[c] = g_ref(md, n, av >> (c * n));
      for (int s = dl - 1; s >= 1; s--) m_pipe[k][s] = m_pipe[k][s-1];
      m_pipe[k][0] = ng;
      m_ye[k] = m_y[k] ^ m_yp[k];
      m_yp[k] = m_y[k];
      m_y[k]  = ny;
    end
  endtask

  // One clock: capture the applied inputs, let the edge happen, advance the model,
  // and leave time 1 unit past the edge for sampling.
  task automatic tick();
    logic r;
    logic [2:0] s1, s2, s3;
    logic [7:0] v1, v2, v3;
    r = rst; s1 = m1; s2 = m2; s3 = m3;
    v1 = a1; v2 = {2'b00, a2}; v3 = a3;
    @(posedge clk);
    model_step(0, r, s1, v1);
    model_step(1, r, s2, v2);
    model_step(2, r, s3, v3);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    total++; if (y1 !== 4'h0)  begin bad++; $display("FAIL reset_y1: got %h expected %h", y1, 4'h0); end
    total++; if (e1 !== 4'h0)  begin bad++; $display("FAIL reset_e1: got %h expected %h", e1, 4'h0); end
    total++; if (y2 !== 2'b10) begin bad++; $display("FAIL reset_y2: got %b expected %b", y2, 2'b10); end
    total++; if (e2 !== 2'b00) begin bad++; $display("FAIL reset_e2: got %b expected %b", e2, 2'b00); end
    total++; if (y3 !== 4'h0)  begin bad++; $display("FAIL reset_y3: got %h expected %h", y3, 4'h0); end
    total++; if (e3 !== 4'h0)  begin bad++; $display("FAIL reset_e3: got %h expected %h", e3, 4'h0); end
    rst = 1'b0;
  endtask

  task automatic test_nor_basic();
    m1 = 3'd0; a1 = 8'h00;
    tick();
    total++; if (y1 !== 4'h0) begin bad++; $display("FAIL nor_lat1: got %h expected %h", y1, 4'h0); end
    tick();
    total++; if (y1 !== 4'hF) begin bad++; $display("FAIL nor_lat2: got %h expected %h", y1, 4'hF); end
    a1 = 8'h03;
    tick();
    total++; if (e1 !== 4'hF) begin bad++; $display("FAIL nor_edge_rise: got %h expected %h", e1, 4'hF); end
    total++; if (y1 !== 4'hF) begin bad++; $display("FAIL nor_hold: got %h expected %h", y1, 4'hF); end
    tick();
    total++; if (y1 !== 4'hE) begin bad++; $display("FAIL nor_ch0_low: got %h expected %h", y1, 4'hE); end
    total++; if (e1 !== 4'h0) begin bad++; $display("FAIL nor_edge_gap: got %h expected %h", e1, 4'h0); end
    tick();
    total++; if (e1 !== 4'h1) begin bad++; $display("FAIL nor_edge_ch0: got %h expected %h", e1, 4'h1); end
    tick();
    total++; if (e1 !== 4'h0) begin bad++; $display("FAIL nor_edge_once: got %h expected %h", e1, 4'h0); end
  endtask

  task automatic test_all_modes();
    logic [1:0] exp_q[$];
    logic [1:0] gv, ex;
    for (int md = 0; md < 8; md++) begin
      for (int v = 0; v < 64; v++) begin
        m2 = 3'(md); a2 = 6'(v);
        gv[0] = g_ref(3'(md), 3, 8'(v));
        gv[1] = g_ref(3'(md), 3, 8'(v >> 3));
        exp_q.push_back(gv);
        tick();
        if (exp_q.size() == 3) begin
          ex = exp_q.pop_front();
          total++;
          if (y2 !== ex) begin
            bad++;
            $display("FAIL all_modes md=%0d v=%0d: got %b expected %b", md, v, y2, ex);
          end
        end
      end
    end
  endtask

  task automatic test_glitch();
    logic [3:0] ey, ee;
    m3 = 3'd0; a3 = 8'hFF;
    repeat (12) tick();
    total++; if (y3 !== 4'h0) begin bad++; $display("FAIL glitch_settle: got %h expected %h", y3, 4'h0); end
    a3 = 8'hFC; tick(); tick();
    a3 = 8'hFF;
    for (int i = 0; i < 12; i++) begin
      tick();
      total++;
      if (y3 !== 4'h0 || e3 !== 4'h0) begin
        bad++; $display("FAIL glitch_suppress i=%0d: got y=%h e=%h expected y=0 e=0", i, y3, e3);
      end
    end
    a3 = 8'hFC;
    for (int i = 1; i <= 9; i++) begin
      tick();
      ey = (i >= 7) ? 4'h1 : 4'h0;
      ee = (i == 8) ? 4'h1 : 4'h0;
      total++;
      if (y3 !== ey || e3 !== ee) begin
        bad++; $display("FAIL level_latency i=%0d: got y=%h e=%h expected y=%h e=%h", i, y3, e3, ey, ee);
      end
    end
  endtask

  task automatic test_bounce();
    logic [3:0] ey, ee;
    for (int i = 1; i <= 12; i++) begin
      a3 = (i == 3) ? 8'hFC : 8'hFF;
      tick();
      ey = (i >= 10) ? 4'h0 : 4'h1;
      ee = (i == 11) ? 4'h1 : 4'h0;
      total++;
      if (y3 !== ey || e3 !== ee) begin
        bad++; $display("FAIL bounce i=%0d: got y=%h e=%h expected y=%h e=%h", i, y3, e3, ey, ee);
      end
    end
  endtask

  task automatic test_reset_mid_filter();
    logic [3:0] ey, ee;
    a3 = 8'h00;
    repeat (6) tick();
    total++; if (y3 !== 4'h0) begin bad++; $display("FAIL midfilt_pre: got %h expected %h", y3, 4'h0); end
    rst = 1'b1;
    tick();
    total++;
    if (y3 !== 4'h0 || e3 !== 4'h0) begin
      bad++; $display("FAIL midfilt_rst: got y=%h e=%h expected y=0 e=0", y3, e3);
    end
    rst = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      tick();
      ey = (j >= 7) ? 4'hF : 4'h0;
      ee = (j == 8) ? 4'hF : 4'h0;
      total++;
      if (y3 !== ey || e3 !== ee) begin
        bad++; $display("FAIL midfilt_post j=%0d: got y=%h e=%h expected y=%h e=%h", j, y3, e3, ey, ee);
      end
    end
  endtask

  task automatic test_mode_switch();
    logic [3:0] ey1, ee1;
    logic [1:0] ey2, ee2;
    a1 = 8'hFF; m1 = 3'd3; a2 = 6'h3F; m2 = 3'd3;
    repeat (5) tick();
    total++;
    if (y1 !== 4'hF || y2 !== 2'b11) begin
      bad++; $display("FAIL switch_pre: got y1=%h y2=%b expected y1=f y2=11", y1, y2);
    end
    m1 = 3'd2; m2 = 3'd2;
    for (int j = 1; j <= 5; j++) begin
      tick();
      ey1 = (j >= 2) ? 4'h0 : 4'hF;
      ee1 = (j == 3) ? 4'hF : 4'h0;
      ey2 = (j >= 3) ? 2'b00 : 2'b11;
      ee2 = (j == 4) ? 2'b11 : 2'b00;
      total++;
      if (y1 !== ey1 || e1 !== ee1) begin
        bad++; $display("FAIL switch_u1 j=%0d: got y=%h e=%h expected y=%h e=%h", j, y1, e1, ey1, ee1);
      end
      total++;
      if (y2 !== ey2 || e2 !== ee2) begin
        bad++; $display("FAIL switch_u2 j=%0d: got y=%b e=%b expected y=%b e=%b", j, y2, e2, ey2, ee2);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 79) == 0);
      a1 = 8'($urandom); m1 = 3'($urandom);
      a2 = 6'($urandom); m2 = 3'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        a3 = 8'($urandom); m3 = 3'($urandom);
      end
      tick();
      total++;
      if (y1 !== m_y[0] || e1 !== m_ye[0]) begin
        bad++; $display("FAIL random_u1 i=%0d: got y=%h e=%h expected y=%h e=%h", i, y1, e1, m_y[0], m_ye[0]);
      end
      total++;
      if (y2 !== m_y[1][1:0] || e2 !== m_ye[1][1:0]) begin
        bad++; $display("FAIL random_u2 i=%0d: got y=%b e=%b expected y=%b e=%b", i, y2, e2, m_y[1][1:0], m_ye[1][1:0]);
      end
      total++;
      if (y3 !== m_y[2] || e3 !== m_ye[2]) begin
        bad++; $display("FAIL random_u3 i=%0d: got y=%h e=%h expected y=%h e=%h", i, y3, e3, m_y[2], m_ye[2]);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    m1 = 3'd0; m2 = 3'd0; m3 = 3'd0;
    a1 = 8'h00; a2 = 6'h00; a3 = 8'h00;
    test_reset();
    test_nor_basic();
    test_all_modes();
    test_glitch();
    test_bounce();
    test_reset_mid_filter();
    test_mode_switch();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
